// File: rtl/uart_echo_ctrl.sv
// UART echo controller: rx edge-detect, byte FIFO and tx handshake FSM.
// Define UART_ECHO_CRLF_EN to expand each echoed CR (0x0D) into CR LF.
module uart_echo_ctrl #(
  parameter int FIFO_DEPTH      = 16,
  parameter int DROP_PARITY_ERR = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_parity_error,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_ECHO_CRLF_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_LF
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;
`endif

  state_t state_q;
  state_t state_d;

  logic          rx_prev_q;
  logic          push_evt;
  logic          par_bad;
  logic          push_ok;
  logic          wr_en;
  logic          pop;
  logic          empty;
  logic          full;
  logic          ovf_evt;
  logic          drop_inc;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          ovf_q;
  logic [7:0]    drop_q;
`ifdef UART_ECHO_CRLF_EN
  logic          load_lf;
`endif

  assign push_evt = rx_ready & ~rx_prev_q;
  assign par_bad  = (DROP_PARITY_ERR != 0) & rx_parity_error;
  assign push_ok  = push_evt & enable & ~par_bad;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  // A full FIFO still takes the byte when the head leaves this cycle
  assign wr_en    = push_ok & (~full | pop);
  assign ovf_evt  = push_ok & full & ~pop;
  assign drop_inc = ovf_evt | (push_evt & enable & par_bad);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
`ifdef UART_ECHO_CRLF_EN
    load_lf = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable && !empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (tx_busy)
          state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
          if (tx_data_q == 8'h0D)
            state_d = S_LF;
          else
            state_d = S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_ECHO_CRLF_EN
      S_LF: begin
        load_lf = 1'b1;
        state_d = S_START;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_prev_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rx_prev_q  <= rx_ready;
      tx_start_q <= (state_q == S_START);
      if (pop)
        tx_data_q <= mem[rd_ptr_q];
`ifdef UART_ECHO_CRLF_EN
      else if (load_lf)
        tx_data_q <= 8'h0A;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // clear wins over a same-cycle overflow or drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'h00;
    end else if (clear) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'h00;
    end else begin
      if (ovf_evt)
        ovf_q <= 1'b1;
      if (drop_inc && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: queued expected echoes,
// monitor pops on every tx_start; directed status checks in between.
module tb_uart_echo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_parity_error = 1'b0;
  logic       tx_busy;
  logic       busy_m = 1'b0;
  logic       busy_stuck = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  logic [7:0] exp_q[$];

  assign tx_busy = busy_m | busy_stuck;

  uart_echo_ctrl #(
    .FIFO_DEPTH(16),
    .DROP_PARITY_ERR(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clear(clear),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_parity_error(rx_parity_error),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
`ifdef UART_ECHO_CRLF_EN
    if (b == 8'h0D)
      exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic send(input logic [7:0] b, input logic pe,
                      input bit echo);
    @(negedge clk);
    rx_data = b;
    rx_parity_error = pe;
    rx_ready = 1'b1;
    if (echo)
      push_exp(b);
    @(negedge clk);
    rx_ready = 1'b0;
    rx_parity_error = 1'b0;
  endtask

  task automatic wait_drain();
    int quiet = 0;
    int t = 0;
    while (quiet < 4 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
      if (exp_q.size() == 0 && !tx_busy)
        quiet++;
      else
        quiet = 0;
    end
    if (quiet < 4) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Transmitter model: busy one cycle after start, for 10 cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_start) begin
      @(posedge clk);
      #1;
      busy_m = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      busy_m = 1'b0;
    end
  end

  // Monitor: each tx_start must match the oldest expected byte
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_start) begin
      n_start++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx_start: got %0h expected none",
                 tx_data);
      end else begin
        chk("echo_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int t;
    int exp_n;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_start", {31'h0, tx_start}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_count", {27'h0, fifo_count}, 0);
    chk("rst_overflow", {31'h0, overflow}, 0);
    chk("rst_drop", {24'h0, drop_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte latency
    rx_data = 8'h41;
    rx_ready = 1'b1;
    push_exp(8'h41);
    @(posedge clk);
    @(negedge clk);
    rx_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_early", {31'h0, tx_start}, 0);
    @(posedge clk);
    #1;
    chk("lat_3cyc", {31'h0, tx_start}, 1);
    wait_drain();
    chk("lat_count0", {27'h0, fifo_count}, 0);

    // overflow with transmitter stuck
    @(negedge clk);
    busy_stuck = 1'b1;
    for (int i = 0; i < 17; i++)
      send(8'(i), 1'b0, i < 16);
    @(posedge clk);
    #1;
    chk("ovf_count16", {27'h0, fifo_count}, 16);
    chk("ovf_flag", {31'h0, overflow}, 1);
    chk("ovf_drop1", {24'h0, drop_count}, 1);
    @(negedge clk);
    busy_stuck = 1'b0;
    wait_drain();
    chk("ovf_count0", {27'h0, fifo_count}, 0);
    chk("ovf_sticky", {31'h0, overflow}, 1);
    do_clear();
    chk("clr_overflow", {31'h0, overflow}, 0);
    chk("clr_drop", {24'h0, drop_count}, 0);

    // parity drop
    s0 = n_start;
    send(8'h55, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("par_drop1", {24'h0, drop_count}, 1);
    chk("par_no_ovf", {31'h0, overflow}, 0);
    chk("par_no_tx", n_start - s0, 0);
    do_clear();

    // full FIFO, push coincident with pop
    @(negedge clk);
    busy_stuck = 1'b1;
    for (int i = 0; i < 16; i++)
      send(8'hB0 + 8'(i), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("full_count16", {27'h0, fifo_count}, 16);
    @(negedge clk);
    busy_stuck = 1'b0;
    rx_data = 8'hA5;
    rx_ready = 1'b1;
    push_exp(8'hA5);
    @(posedge clk);
    #1;
    chk("cpop_count16", {27'h0, fifo_count}, 16);
    chk("cpop_no_ovf", {31'h0, overflow}, 0);
    @(negedge clk);
    rx_ready = 1'b0;
    wait_drain();
    chk("cpop_drop0", {24'h0, drop_count}, 0);

    // held-high rx_ready pushes once
    s0 = n_start;
    @(negedge clk);
    rx_data = 8'h33;
    rx_ready = 1'b1;
    push_exp(8'h33);
    repeat (6) @(negedge clk);
    rx_ready = 1'b0;
    wait_drain();
    chk("held_one_echo", n_start - s0, 1);

    // enable low blocks pushes and pops, keeps contents
    @(negedge clk);
    enable = 1'b0;
    send(8'h77, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("dis_no_push", {27'h0, fifo_count}, 0);
    @(negedge clk);
    enable = 1'b1;
    busy_stuck = 1'b1;
    send(8'hC1, 1'b0, 1'b1);
    send(8'hC2, 1'b0, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    busy_stuck = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("dis_retain2", {27'h0, fifo_count}, 2);
    @(negedge clk);
    enable = 1'b1;
    wait_drain();
    chk("dis_count0", {27'h0, fifo_count}, 0);

    // carriage return
`ifdef UART_ECHO_CRLF_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    s0 = n_start;
    send(8'h0D, 1'b0, 1'b1);
    wait_drain();
    chk("cr_pulses", n_start - s0, exp_n);

    // reset during WAIT_DONE with 3 bytes buffered
    @(negedge clk);
    busy_stuck = 1'b1;
    send(8'hE1, 1'b0, 1'b1);
    send(8'hE2, 1'b0, 1'b0);
    send(8'hE3, 1'b0, 1'b0);
    send(8'hE4, 1'b0, 1'b0);
    @(negedge clk);
    busy_stuck = 1'b0;
    t = 0;
    while (!tx_start && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rstm_started", {31'h0, tx_start}, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("rstm_count3", {27'h0, fifo_count}, 3);
    s0 = n_start;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstm_tx_start", {31'h0, tx_start}, 0);
    chk("rstm_tx_data", {24'h0, tx_data}, 0);
    chk("rstm_count", {27'h0, fifo_count}, 0);
    chk("rstm_overflow", {31'h0, overflow}, 0);
    chk("rstm_drop", {24'h0, drop_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rstm_no_tx", n_start - s0, 0);

    // rx_ready already high at reset release counts as an edge
    @(negedge clk);
    rst_n = 1'b0;
    rx_data = 8'h5A;
    rx_ready = 1'b1;
    push_exp(8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    wait_drain();
    chk("rel_count0", {27'h0, fifo_count}, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
